// File: rtl/svc_soc_gpio_reg_if.sv
// MMIO write/read bus between an SoC I/O master and the GPIO register bank.
interface svc_soc_gpio_reg_if;
  logic        io_wen;
  logic [31:0] io_waddr;
  logic [31:0] io_wdata;
  logic [3:0]  io_wstrb;
  logic        io_ren;
  logic [31:0] io_raddr;
  logic [31:0] io_rdata;
  logic        io_rvalid;

  modport master (
    output io_wen, io_waddr, io_wdata, io_wstrb, io_ren, io_raddr,
    input  io_rdata, io_rvalid
  );

  modport slave (
    input  io_wen, io_waddr, io_wdata, io_wstrb, io_ren, io_raddr,
    output io_rdata, io_rvalid
  );
endinterface

// File: rtl/svc_soc_gpio_reg.sv
// GPIO register bank: output pins with set/clear/toggle, synchronized inputs,
// sticky rising-edge status with a level interrupt, and 1-cycle registered reads.
module svc_soc_gpio_reg #(
  parameter int unsigned         NUM_OUT     = 8,
  parameter int unsigned         NUM_IN      = 8,
  parameter int unsigned         SYNC_STAGES = 2,
  parameter logic [NUM_OUT-1:0]  OUT_RESET   = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  svc_soc_gpio_reg_if.slave      bus,
  output logic [NUM_OUT-1:0]     gpio_out,
  input  logic [NUM_IN-1:0]      gpio_in,
  output logic                   irq
);

  localparam int unsigned DW         = 32;
  localparam logic [7:0]  OFF_OUT    = 8'h00;
  localparam logic [7:0]  OFF_SET    = 8'h04;
  localparam logic [7:0]  OFF_CLR    = 8'h08;
  localparam logic [7:0]  OFF_TGL    = 8'h0C;
  localparam logic [7:0]  OFF_IN     = 8'h10;
  localparam logic [7:0]  OFF_IRQ_EN = 8'h14;
  localparam logic [7:0]  OFF_STATUS = 8'h18;

  logic [NUM_OUT-1:0] out_q,    out_d;
  logic [NUM_IN-1:0]  irq_en_q, irq_en_d;
  logic [NUM_IN-1:0]  status_q, status_d;
  logic [NUM_IN-1:0]  prev_q,   prev_d;
  logic [NUM_IN-1:0]  sync_q [SYNC_STAGES];
  logic [NUM_IN-1:0]  sync_d [SYNC_STAGES];
  logic [DW-1:0]      rdata_q,  rdata_d;
  logic               rvalid_q, rvalid_d;
  logic               irq_q,    irq_d;

  logic [DW-1:0]      byte_mask;
  logic [DW-1:0]      wdata_m;
  logic [DW-1:0]      out_ext;
  logic [DW-1:0]      rd_mux;
  logic [NUM_IN-1:0]  in_val;
  logic [NUM_IN-1:0]  rise;
  logic [NUM_IN-1:0]  clr_mask;
  logic               unused_addr_hi;

  assign unused_addr_hi = ^{bus.io_waddr[31:8], bus.io_raddr[31:8]};

  // Input synchronizer; the last stage is the architectural IN value.
  always_comb begin
    sync_d[0] = gpio_in;
    for (int i = 1; i < int'(SYNC_STAGES); i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign in_val = sync_q[SYNC_STAGES-1];
  assign rise   = in_val & ~prev_q;

  // Write decode: every write type only touches strobed bytes.
  always_comb begin
    byte_mask = {{8{bus.io_wstrb[3]}}, {8{bus.io_wstrb[2]}},
                 {8{bus.io_wstrb[1]}}, {8{bus.io_wstrb[0]}}};
    wdata_m   = bus.io_wdata & byte_mask;
    out_ext   = DW'(out_q);
    out_d     = out_q;
    irq_en_d  = irq_en_q;
    clr_mask  = '0;
    if (bus.io_wen) begin
      case (bus.io_waddr[7:0])
        OFF_OUT:    out_d    = NUM_OUT'((out_ext & ~byte_mask) | wdata_m);
        OFF_SET:    out_d    = NUM_OUT'(out_ext | wdata_m);
        OFF_CLR:    out_d    = NUM_OUT'(out_ext & ~wdata_m);
        OFF_TGL:    out_d    = NUM_OUT'(out_ext ^ wdata_m);
        OFF_IRQ_EN: irq_en_d = NUM_IN'((DW'(irq_en_q) & ~byte_mask) | wdata_m);
        OFF_STATUS: clr_mask = NUM_IN'(wdata_m);
        default:    ;
      endcase
    end
    // A same-cycle edge overrides the W1C clear.
    status_d = (status_q & ~clr_mask) | rise;
    prev_d   = in_val;
    irq_d    = |(status_q & irq_en_q);
  end

  // Read path samples pre-write state; rdata holds between reads.
  always_comb begin
    case (bus.io_raddr[7:0])
      OFF_OUT:    rd_mux = DW'(out_q);
      OFF_IN:     rd_mux = DW'(in_val);
      OFF_IRQ_EN: rd_mux = DW'(irq_en_q);
      OFF_STATUS: rd_mux = DW'(status_q);
      default:    rd_mux = '0;
    endcase
    rvalid_d = bus.io_ren;
    rdata_d  = bus.io_ren ? rd_mux : rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q    <= OUT_RESET;
      irq_en_q <= '0;
      status_q <= '0;
      prev_q   <= '0;
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= '0;
      end
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      out_q    <= out_d;
      irq_en_q <= irq_en_d;
      status_q <= status_d;
      prev_q   <= prev_d;
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_d[i];
      end
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      irq_q    <= irq_d;
    end
  end

  assign gpio_out      = out_q;
  assign irq           = irq_q;
  assign bus.io_rdata  = rdata_q;
  assign bus.io_rvalid = rvalid_q;

endmodule

// File: tb/tb_svc_soc_gpio_reg.sv
// Bench for svc_soc_gpio_reg: directed register-map scenarios followed by random
// traffic, all checked against a cycle-level model of the register bank.
module tb_svc_soc_gpio_reg;

  localparam int unsigned SYNC = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] gpio_out0, gpio_in0;
  logic       irq0;
  logic [3:0] gpio_out1, gpio_in1;
  logic       irq1;

  svc_soc_gpio_reg_if bus0 ();
  svc_soc_gpio_reg_if bus1 ();

  always #5 clk = ~clk;

  svc_soc_gpio_reg #(
    .NUM_OUT(8), .NUM_IN(8), .SYNC_STAGES(SYNC), .OUT_RESET(8'hA5)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0),
    .gpio_out(gpio_out0), .gpio_in(gpio_in0), .irq(irq0)
  );

  svc_soc_gpio_reg #(
    .NUM_OUT(4), .NUM_IN(4), .SYNC_STAGES(3), .OUT_RESET(4'h0)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1),
    .gpio_out(gpio_out1), .gpio_in(gpio_in1), .irq(irq1)
  );

  int checks   = 0;
  int failures = 0;

  // Model state for dut0: registers plus a history of sampled pin values.
  logic [7:0]  m_out, m_irq_en, m_status, m_prev;
  logic [31:0] m_rdata;
  logic        m_rvalid, m_irq;
  logic [7:0]  hist[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_out    = 8'hA5;
    m_irq_en = 8'h00;
    m_status = 8'h00;
    m_prev   = 8'h00;
    m_rdata  = 32'h0;
    m_rvalid = 1'b0;
    m_irq    = 1'b0;
    hist.delete();
    repeat (SYNC) hist.push_back(8'h00);
  endtask

  // One rising edge of the bank, computed from pre-edge state and bench-driven inputs.
  task automatic model_edge();
    logic [31:0] bm, wd;
    logic [7:0]  in_cur, rise, clr;
    bm = {{8{bus0.io_wstrb[3]}}, {8{bus0.io_wstrb[2]}},
          {8{bus0.io_wstrb[1]}}, {8{bus0.io_wstrb[0]}}};
    wd     = bus0.io_wdata & bm;
    in_cur = hist[SYNC-1];
    rise   = in_cur & ~m_prev;
    if (bus0.io_ren) begin
      case (bus0.io_raddr[7:0])
        8'h00:   m_rdata = {24'h0, m_out};
        8'h10:   m_rdata = {24'h0, in_cur};
        8'h14:   m_rdata = {24'h0, m_irq_en};
        8'h18:   m_rdata = {24'h0, m_status};
        default: m_rdata = 32'h0;
      endcase
    end
    m_rvalid = bus0.io_ren;
    m_irq    = |(m_status & m_irq_en);
    clr      = 8'h00;
    if (bus0.io_wen) begin
      case (bus0.io_waddr[7:0])
        8'h00: m_out    = (m_out & ~bm[7:0]) | wd[7:0];
        8'h04: m_out    = m_out | wd[7:0];
        8'h08: m_out    = m_out & ~wd[7:0];
        8'h0C: m_out    = m_out ^ wd[7:0];
        8'h14: m_irq_en = (m_irq_en & ~bm[7:0]) | wd[7:0];
        8'h18: clr      = wd[7:0];
        default: ;
      endcase
    end
    m_status = (m_status & ~clr) | rise;
    m_prev   = in_cur;
    hist.push_front(gpio_in0);
    void'(hist.pop_back());
  endtask

  task automatic check_all();
    chk("gpio_out", 32'(gpio_out0), 32'(m_out));
    chk("irq",      32'(irq0),      32'(m_irq));
    chk("rvalid",   32'(bus0.io_rvalid), 32'(m_rvalid));
    chk("rdata",    bus0.io_rdata,  m_rdata);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
    bus0.io_wen = 1'b0;
    bus0.io_ren = 1'b0;
    bus1.io_wen = 1'b0;
    bus1.io_ren = 1'b0;
  endtask

  task automatic wr0(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    bus0.io_wen   = 1'b1;
    bus0.io_waddr = {24'h0, a};
    bus0.io_wdata = d;
    bus0.io_wstrb = s;
  endtask

  task automatic rd0(input logic [7:0] a);
    bus0.io_ren   = 1'b1;
    bus0.io_raddr = {24'h0, a};
  endtask

  task automatic rd1(input logic [7:0] a);
    bus1.io_ren   = 1'b1;
    bus1.io_raddr = {24'h0, a};
  endtask

  initial begin
    logic [31:0] r;
    rst_n = 1'b0;
    bus0.io_wen = 1'b0; bus0.io_waddr = '0; bus0.io_wdata = '0; bus0.io_wstrb = '0;
    bus0.io_ren = 1'b0; bus0.io_raddr = '0;
    bus1.io_wen = 1'b0; bus1.io_waddr = '0; bus1.io_wdata = '0; bus1.io_wstrb = '0;
    bus1.io_ren = 1'b0; bus1.io_raddr = '0;
    gpio_in0 = 8'h00;
    gpio_in1 = 4'h0;
    model_reset();
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_gpio_out", 32'(gpio_out0), 32'h0000_00A5);
    chk("rst_irq",      32'(irq0), 32'h0);
    chk("rst_rvalid",   32'(bus0.io_rvalid), 32'h0);
    chk("rst_out1",     32'(gpio_out1), 32'h0);
    rst_n = 1'b1;
    rd0(8'h00); tick();
    chk("rst_read_out", bus0.io_rdata, 32'h0000_00A5);

    // Write types and byte strobes
    wr0(8'h00, 32'h0000_000F, 4'hF); tick(); chk("out_wr", 32'(gpio_out0), 32'h0F);
    wr0(8'h04, 32'h0000_00F0, 4'h1); tick(); chk("out_set", 32'(gpio_out0), 32'hFF);
    wr0(8'h08, 32'h0000_0081, 4'h1); tick(); chk("out_clr", 32'(gpio_out0), 32'h7E);
    wr0(8'h0C, 32'h0000_00FF, 4'h1); tick(); chk("out_tgl", 32'(gpio_out0), 32'h81);
    wr0(8'h00, 32'h0000_0000, 4'h0); tick(); chk("out_nostrb", 32'(gpio_out0), 32'h81);
    wr0(8'h00, 32'hFFFF_FF00, 4'hE); tick(); chk("out_hi_lanes", 32'(gpio_out0), 32'h81);
    rd0(8'h04); tick(); chk("set_reads0", bus0.io_rdata, 32'h0);

    // Synchronizer latency and edge capture
    gpio_in0 = 8'h01;
    rd0(8'h10); tick(); chk("in_c0", bus0.io_rdata, 32'h0);
    rd0(8'h10); tick(); chk("in_c1", bus0.io_rdata, 32'h0);
    rd0(8'h10); tick(); chk("in_c2", bus0.io_rdata, 32'h1);
    rd0(8'h18); tick(); chk("status_c3", bus0.io_rdata, 32'h1);
    chk("irq_disabled", 32'(irq0), 32'h0);

    // Enabling with a pending flag, then W1C
    wr0(8'h14, 32'h0000_0001, 4'h1); tick(); chk("irq_lag", 32'(irq0), 32'h0);
    tick(); chk("irq_on", 32'(irq0), 32'h1);
    wr0(8'h18, 32'h0000_0001, 4'h1); tick(); chk("irq_hold", 32'(irq0), 32'h1);
    rd0(8'h18); tick(); chk("irq_off", 32'(irq0), 32'h0);
    chk("status_cleared", bus0.io_rdata, 32'h0);

    // Edge beats a same-cycle W1C
    gpio_in0 = 8'h00;
    repeat (3) tick();
    gpio_in0 = 8'h01;
    tick(); tick();
    wr0(8'h18, 32'h0000_0001, 4'h1); tick();
    rd0(8'h18); tick(); chk("edge_wins", bus0.io_rdata, 32'h1);

    // Narrow instance: masked bits, unmapped offset, reset during a read
    bus1.io_wen = 1'b1; bus1.io_waddr = 32'h0; bus1.io_wdata = 32'h0000_00FF; bus1.io_wstrb = 4'hF;
    tick(); chk("n4_out", 32'(gpio_out1), 32'hF);
    rd1(8'h00); tick();
    chk("n4_rvalid", 32'(bus1.io_rvalid), 32'h1);
    chk("n4_read_out", bus1.io_rdata, 32'h0000_000F);
    rd1(8'h1C); tick(); chk("n4_unmapped", bus1.io_rdata, 32'h0);
    rd1(8'h00);
    @(posedge clk);
    #2;
    chk("n4_rvalid_pre_rst", 32'(bus1.io_rvalid), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_rvalid", 32'(bus1.io_rvalid), 32'h0);
    chk("rst_mid_out0", 32'(gpio_out0), 32'hA5);
    model_reset();
    @(negedge clk);
    bus1.io_ren = 1'b0;
    rst_n = 1'b1;
    tick();

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      r = $urandom;
      bus0.io_wen   = r[0];
      bus0.io_ren   = r[1];
      bus0.io_wstrb = r[7:4];
      r = $urandom;
      bus0.io_waddr = {r[31:8], 8'(4 * $urandom_range(0, 8))};
      r = $urandom;
      bus0.io_raddr = {r[31:8], 8'(4 * $urandom_range(0, 8))};
      bus0.io_wdata = $urandom;
      if ($urandom_range(0, 3) == 0) gpio_in0 = 8'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
